// File: rtl/silife_grid_engine_if.sv
// silife_grid_engine_if
//   Host-side bus of the Game-of-Life grid engine.
//   master : the host / tile I/O wrapper (drives controls and write data)
//   slave  : the grid engine (drives read data and status)
//   Signals:
//     wr_en      host->engine  write grid_in into row row_select
//     step       host->engine  request one generation (level-sampled)
//     row_select host->engine  row address for writes and reads
//     grid_in    host->engine  row write data, bit c is column c
//     grid_out   engine->host  combinational read of row row_select
//     busy       engine->host  generation in progress
//     done       engine->host  one-cycle pulse when a generation completes
//     gen_count  engine->host  completed generations, wraps modulo 2^16
interface silife_grid_engine_if #(
    parameter int WIDTH    = 8,
    parameter int ROW_BITS = 3
);
    logic                wr_en;
    logic                step;
    logic [ROW_BITS-1:0] row_select;
    logic [WIDTH-1:0]    grid_in;
    logic [WIDTH-1:0]    grid_out;
    logic                busy;
    logic                done;
    logic [15:0]         gen_count;

    modport master (
        output wr_en, step, row_select, grid_in,
        input  grid_out, busy, done, gen_count
    );

    modport slave (
        input  wr_en, step, row_select, grid_in,
        output grid_out, busy, done, gen_count
    );
endinterface

// File: rtl/silife_grid_engine.sv
// silife_grid_engine
//   WIDTH x HEIGHT Game-of-Life cell array (B3/S23) with row-addressed
//   write/read access and a row-serial next-generation engine that rewrites
//   one row per clock.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset (clears grid, counters, FSM)
//     bus    silife_grid_engine_if.slave (wr_en, step, row_select, grid_in,
//            grid_out, busy, done, gen_count)
//   Configuration macro:
//     SILIFE_TORUS_EN  defined   -> row and column edges wrap (toroidal grid)
//                      undefined -> cells outside the grid are dead
module silife_grid_engine #(
    parameter int WIDTH    = 8,
    parameter int HEIGHT   = 8,
    parameter int ROW_BITS = $clog2(HEIGHT)
) (
    input  logic                clk,
    input  logic                rst_n,
    silife_grid_engine_if.slave bus
);

    typedef enum logic {
        IDLE,
        COMPUTE
    } state_t;

    localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(HEIGHT - 1);
    localparam logic [ROW_BITS:0]   HEIGHT_W = (ROW_BITS + 1)'(HEIGHT);

    state_t              state;
    state_t              state_nxt;

    logic [WIDTH-1:0]    grid [HEIGHT];
    logic [ROW_BITS-1:0] row_idx;
    logic [WIDTH-1:0]    prev_row;
    logic [WIDTH-1:0]    first_row;
    logic                done_q;
    logic [15:0]         gen_count_q;

    // FSM decode
    logic                start;
    logic                row_commit;
    logic                finish;
    logic                host_wr;

    // Addressing
    logic                row_ok;
    logic [ROW_BITS-1:0] acc_idx;
    logic                last_row;
    logic [ROW_BITS-1:0] nxt_idx;

    // Datapath
    logic [WIDTH-1:0]    cur_row;
    logic [WIDTH-1:0]    nxt_row;
    logic [WIDTH-1:0]    start_prev;
    logic [WIDTH+1:0]    ext_prev;
    logic [WIDTH+1:0]    ext_cur;
    logic [WIDTH+1:0]    ext_nxt;
    logic [3:0]          nbr_cnt;
    logic [WIDTH-1:0]    new_row;

    // Widen a row by one column on each side: bit 0 is column -1 and
    // bit WIDTH+1 is column WIDTH, so every cell sees its neighbours at a
    // fixed offset and no per-column edge case remains.
    function automatic logic [WIDTH+1:0] pad_row(input logic [WIDTH-1:0] r);
`ifdef SILIFE_TORUS_EN
        return {r[0], r, r[WIDTH-1]};
`else
        return {1'b0, r, 1'b0};
`endif
    endfunction

    // ------------------------------------------------------------------
    // Addressing
    // ------------------------------------------------------------------
    assign row_ok   = ({1'b0, bus.row_select} < HEIGHT_W);
    assign acc_idx  = row_ok ? bus.row_select : '0;
    assign last_row = (row_idx == LAST_ROW);
    assign nxt_idx  = last_row ? '0 : row_idx + ROW_BITS'(1);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        start      = 1'b0;
        row_commit = 1'b0;
        finish     = 1'b0;
        host_wr    = 1'b0;
        unique case (state)
            IDLE: begin
                // A write takes priority over a step request.
                if (bus.wr_en) begin
                    host_wr = row_ok;
                end else if (bus.step) begin
                    start     = 1'b1;
                    state_nxt = COMPUTE;
                end
            end
            COMPUTE: begin
                row_commit = 1'b1;
                if (last_row) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Neighbour rows for the row under evaluation
    // ------------------------------------------------------------------
    assign cur_row = grid[row_idx];

`ifdef SILIFE_TORUS_EN
    assign start_prev = grid[LAST_ROW];
    assign nxt_row    = last_row ? first_row : grid[nxt_idx];
`else
    assign start_prev = '0;
    // first_row is still captured in this build; masking it keeps the
    // register visible without letting it influence the result.
    assign nxt_row    = last_row ? (first_row & {WIDTH{1'b0}}) : grid[nxt_idx];
`endif

    assign ext_prev = pad_row(prev_row);
    assign ext_cur  = pad_row(cur_row);
    assign ext_nxt  = pad_row(nxt_row);

    // ------------------------------------------------------------------
    // B3/S23 rule, one row per cycle
    // ------------------------------------------------------------------
    always_comb begin
        new_row = '0;
        nbr_cnt = '0;
        for (int unsigned c = 0; c < WIDTH; c++) begin
            // Cell c sits at ext index c+1; neighbours are c, c+1, c+2.
            nbr_cnt = 4'(ext_prev[c]) + 4'(ext_prev[c+1]) + 4'(ext_prev[c+2])
                    + 4'(ext_cur[c])                      + 4'(ext_cur[c+2])
                    + 4'(ext_nxt[c])  + 4'(ext_nxt[c+1])  + 4'(ext_nxt[c+2]);
            new_row[c] = (nbr_cnt == 4'd3) | (ext_cur[c+1] & (nbr_cnt == 4'd2));
        end
    end

    // ------------------------------------------------------------------
    // Grid storage, row index, carried rows, status
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < HEIGHT; r++) begin
                grid[r] <= '0;
            end
            row_idx     <= '0;
            prev_row    <= '0;
            first_row   <= '0;
            done_q      <= 1'b0;
            gen_count_q <= '0;
        end else begin
            done_q <= finish;
            if (host_wr) begin
                grid[acc_idx] <= bus.grid_in;
            end
            if (start) begin
                row_idx   <= '0;
                first_row <= grid[0];
                prev_row  <= start_prev;
            end
            if (row_commit) begin
                // prev_row carries the original (pre-update) row i, since
                // grid[i] is overwritten on this same edge.
                grid[row_idx] <= new_row;
                prev_row      <= cur_row;
                row_idx       <= nxt_idx;
            end
            if (finish) begin
                gen_count_q <= gen_count_q + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.grid_out  = row_ok ? grid[acc_idx] : '0;
    assign bus.busy      = (state == COMPUTE);
    assign bus.done      = done_q;
    assign bus.gen_count = gen_count_q;

endmodule

// File: tb/tb_silife_grid_engine.sv
// tb_silife_grid_engine
//   Directed bench for silife_grid_engine (WIDTH=8, HEIGHT=8). Expected
//   values are pushed to a scoreboard queue as stimulus is driven and
//   popped when the corresponding DUT output is sampled. Grid images are
//   packed as 64-bit words, row r in bits [8r+7:8r].
module tb_silife_grid_engine;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int RB = 3;

    logic clk;
    logic rst_n;

    silife_grid_engine_if #(.WIDTH(W), .ROW_BITS(RB)) bus ();

    silife_grid_engine #(
        .WIDTH   (W),
        .HEIGHT  (H),
        .ROW_BITS(RB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } sb_t;

    sb_t sb_q[$];
    int  total;
    int  bad;
    int  exp_gen;

    function automatic void sb_push(input string tag, input logic [63:0] val);
        sb_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endfunction

    task automatic check_next(input logic [63:0] obs);
        sb_t e;
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty: observed %0h with no expectation", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val)
            else begin
                bad++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_row(input int r, input logic [7:0] v);
        bus.wr_en      = 1'b1;
        bus.row_select = RB'(r);
        bus.grid_in    = v;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic check_grid(input string name, input logic [63:0] img);
        logic [63:0] tmp;
        tmp = img;
        for (int r = 0; r < H; r++) begin
            bus.row_select = RB'(r);
            #1;
            sb_push($sformatf("%s_row%0d", name, r), {56'd0, tmp[8*r +: 8]});
            check_next({56'd0, bus.grid_out});
        end
    endtask

    task automatic check_status(input string name);
        sb_push({name, "_busy"}, 64'd0);
        check_next({63'd0, bus.busy});
        sb_push({name, "_done"}, 64'd0);
        check_next({63'd0, bus.done});
        sb_push({name, "_gen"}, 64'(exp_gen));
        check_next({48'd0, bus.gen_count});
    endtask

    task automatic do_reset();
        bus.wr_en = 1'b0;
        bus.step  = 1'b0;
        rst_n     = 1'b0;
        #7;
        rst_n     = 1'b1;
        exp_gen   = 0;
        tick();
    endtask

    // Raise step for 'hold' edges, optionally inject a write to row 5 while
    // busy, then wait (bounded) for done and check the handshake.
    task automatic run_gen(input int hold, input bit inject);
        int busy_cycles;
        int waited;
        busy_cycles = 0;
        waited      = 0;
        bus.step = 1'b1;
        tick();
        for (int k = 1; k < hold; k++) begin
            if (bus.busy) busy_cycles++;
            tick();
        end
        bus.step = 1'b0;
        while (!bus.done && waited < 40) begin
            if (bus.busy) busy_cycles++;
            if (inject && waited == 1) begin
                bus.wr_en      = 1'b1;
                bus.row_select = 3'd5;
                bus.grid_in    = 8'hFF;
            end
            tick();
            bus.wr_en = 1'b0;
            waited++;
        end
        exp_gen = (exp_gen + 1) % 65536;
        sb_push("busy_cycles", 64'(H));
        check_next(64'(busy_cycles));
        sb_push("done_pulse", 64'd1);
        check_next({63'd0, bus.done});
        sb_push("busy_after", 64'd0);
        check_next({63'd0, bus.busy});
        sb_push("gen_count", 64'(exp_gen));
        check_next({48'd0, bus.gen_count});
        tick();
        sb_push("done_one_cycle", 64'd0);
        check_next({63'd0, bus.done});
        sb_push("no_restart", 64'd0);
        check_next({63'd0, bus.busy});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_seen;
        total          = 0;
        bad            = 0;
        exp_gen        = 0;
        bus.wr_en      = 1'b0;
        bus.step       = 1'b0;
        bus.row_select = '0;
        bus.grid_in    = '0;
        rst_n          = 1'b0;

        // Reset state
        do_reset();
        check_status("reset");
        check_grid("reset", 64'h0);

        // Blinker: oscillates between horizontal and vertical
        write_row(3, 8'h38);
        check_grid("blinker_wr", 64'h0000_0000_3800_0000);
        run_gen(1, 1'b0);
        check_grid("blinker_g1", 64'h0000_0010_1010_0000);
        run_gen(1, 1'b0);
        check_grid("blinker_g2", 64'h0000_0000_3800_0000);

        // Block still life over three generations
        do_reset();
        write_row(1, 8'h06);
        write_row(2, 8'h06);
        run_gen(1, 1'b0);
        run_gen(1, 1'b0);
        run_gen(1, 1'b0);
        check_grid("block", 64'h0000_0000_0006_0600);
        sb_push("block_gen", 64'd3);
        check_next({48'd0, bus.gen_count});

        // Horizontal edge
        do_reset();
        write_row(3, 8'h83);
        run_gen(1, 1'b0);
`ifdef SILIFE_TORUS_EN
        check_grid("hwrap", 64'h0000_0001_0101_0000);
`else
        check_grid("hwrap", 64'h0);
`endif

        // Vertical edge
        do_reset();
        write_row(0, 8'h38);
        run_gen(1, 1'b0);
`ifdef SILIFE_TORUS_EN
        check_grid("vwrap", 64'h1000_0000_0000_1010);
`else
        check_grid("vwrap", 64'h0000_0000_0000_1010);
`endif

        // Write while busy is dropped
        do_reset();
        write_row(3, 8'h38);
        run_gen(1, 1'b1);
        check_grid("busy_wr", 64'h0000_0010_1010_0000);

        // Step held for three cycles gives one generation
        do_reset();
        write_row(3, 8'h38);
        run_gen(3, 1'b0);
        check_grid("step_hold", 64'h0000_0010_1010_0000);

        // Reset in the middle of a generation
        do_reset();
        write_row(3, 8'h38);
        run_gen(1, 1'b0);
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        tick();
        tick();
        sb_push("mid_busy", 64'd1);
        check_next({63'd0, bus.busy});
        rst_n = 1'b0;
        #2;
        exp_gen = 0;
        check_status("mid_rst");
        check_grid("mid_rst", 64'h0);
        rst_n = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.done) done_seen++;
        end
        sb_push("mid_no_done", 64'd0);
        check_next(64'(done_seen));
        check_status("mid_after");
        check_grid("mid_after", 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
